// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared burst/response encodings and FSM state types for axi_slave_mem
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  // Wrapping bursts are only meaningful for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - next beat address, word index and legality of one burst beat (AXI_SLAVE_MEM_WRAP_EN enables WRAP)
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  legal_o,
  output logic                  ok_o,
  output logic [IDX_W-1:0]      idx_o
);

  localparam int LSB = $clog2(DATA_WIDTH/8);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] word;
  burst_e                burst;

  assign burst     = burst_e'(burst_i);
  assign step      = ADDR_WIDTH'(1) << size_i;
  assign incr_addr = addr_i + step;

  // Word index is not folded: anything past the array is an error beat
  assign word  = addr_i >> LSB;
  assign ok_o  = word < ADDR_WIDTH'(MEM_DEPTH);
  assign idx_o = word[IDX_W-1:0];

`ifdef AXI_SLAVE_MEM_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;
  assign wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  // Burst-type dependent address step and legality of the whole burst
  always_comb begin
    next_addr_o = incr_addr;
    legal_o     = (size_i <= 3'(LSB));
    case (burst)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr_addr;
      BURST_WRAP: begin
`ifdef AXI_SLAVE_MEM_WRAP_EN
        next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
        legal_o     = legal_o && wrap_len_ok(len_i);
`else
        legal_o     = 1'b0;
`endif
      end
      default:     legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI4 memory slave with independent write/read burst FSMs (AXI_SLAVE_MEM_WRAP_EN enables WRAP)
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [7:0]              AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [7:0]              WID,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [7:0]              BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [7:0]              ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [7:0]              RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH/8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Write channel state
  wstate_e               wstate_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [7:0]            bid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            wlen_q, wcnt_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;
  logic                  werr_q;

  // Read channel state; raddr_q is the address of the next beat to fetch
  rstate_e               rstate_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [7:0]            rid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [7:0]            rlen_q, rcnt_q;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q;

  logic [ADDR_WIDTH-1:0] w_next, r_next;
  logic                  w_legal, w_ok, r_legal, r_ok;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic                  w_beat_err, w_last_beat, mem_we;

  // While idle the read generator looks at the AR channel so beat 0 can be fetched on the handshake edge
  logic                  r_idle;
  logic [ADDR_WIDTH-1:0] r_gen_addr;
  logic [7:0]            r_gen_len;
  logic [2:0]            r_gen_size;
  logic [1:0]            r_gen_burst;
  logic                  r_beat_ok;

  logic unused_wid;
  assign unused_wid = ^WID;

  assign r_idle      = (rstate_q == R_IDLE);
  assign r_gen_addr  = r_idle ? ARADDR  : raddr_q;
  assign r_gen_len   = r_idle ? ARLEN   : rlen_q;
  assign r_gen_size  = r_idle ? ARSIZE  : rsize_q;
  assign r_gen_burst = r_idle ? ARBURST : rburst_q;
  assign r_beat_ok   = r_legal && r_ok;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)
  ) u_wgen (
    .addr_i(waddr_q), .len_i(wlen_q), .size_i(wsize_q), .burst_i(wburst_q),
    .next_addr_o(w_next), .legal_o(w_legal), .ok_o(w_ok), .idx_o(w_idx)
  );

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)
  ) u_rgen (
    .addr_i(r_gen_addr), .len_i(r_gen_len), .size_i(r_gen_size), .burst_i(r_gen_burst),
    .next_addr_o(r_next), .legal_o(r_legal), .ok_o(r_ok), .idx_o(r_idx)
  );

  // A WLAST that disagrees with the beat count is flagged but the burst still ends on AWLEN
  assign w_last_beat = (wcnt_q == wlen_q);
  assign w_beat_err  = !(w_legal && w_ok) || (WLAST != w_last_beat);
  assign mem_we      = ARESETn && (wstate_q == W_DATA) && WVALID && w_legal && w_ok;

  // Write FSM: AW capture, beat counting with error accumulation, B response
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (AWVALID && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= AWID;
            waddr_q   <= AWADDR;
            wlen_q    <= AWLEN;
            wsize_q   <= AWSIZE;
            wburst_q  <= AWBURST;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            wstate_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            waddr_q <= w_next;
            wcnt_q  <= wcnt_q + 8'd1;
            werr_q  <= werr_q || w_beat_err;
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              wstate_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Byte-lane writes of accepted legal in-range beats; contents survive reset
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  // Read FSM: prefetch each beat into the R registers and hold them until RREADY
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ARVALID && arready_q) begin
            arready_q <= 1'b0;
            rid_q     <= ARID;
            rlen_q    <= ARLEN;
            rsize_q   <= ARSIZE;
            rburst_q  <= ARBURST;
            raddr_q   <= r_next;
            rcnt_q    <= '0;
            rvalid_q  <= 1'b1;
            rlast_q   <= (ARLEN == 8'd0);
            rdata_q   <= r_beat_ok ? mem[r_idx] : '0;
            rresp_q   <= r_beat_ok ? RESP_OKAY : RESP_SLVERR;
            rstate_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              raddr_q <= r_next;
              rcnt_q  <= rcnt_q + 8'd1;
              rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
              rdata_q <= r_beat_ok ? mem[r_idx] : '0;
              rresp_q <= r_beat_ok ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - randomized self-checking bench for axi_slave_mem against a behavioural memory model
module tb_axi_slave_mem;

  localparam int DEPTH = 1024;

  logic        ACLK, ARESETn;
  logic [7:0]  AWID, AWLEN, WID, BID, ARID, ARLEN, RID;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte address of beat i, computed directly from the start address
  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    logic [31:0] step, bytes, base;
    step = 32'd1 << size;
    case (burst)
      2'd0: return addr;
      2'd2: begin
        bytes = (32'(len) + 1) * step;
        base  = addr - (addr % bytes);
        return base + ((addr - base + 32'(i) * step) % bytes);
      end
      default: return addr + 32'(i) * step;
    endcase
  endfunction

  function automatic logic burst_legal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    if (size > 3'd2) return 1'b0;
    if (burst == 2'd3) return 1'b0;
    if (burst == 2'd2) begin
`ifdef AXI_SLAVE_MEM_WRAP_EN
      return (len == 1) || (len == 3) || (len == 7) || (len == 15);
`else
      return 1'b0;
`endif
    end
    return 1'b1;
  endfunction

  function automatic logic rdy_sig(input int sel);
    case (sel)
      0:       return AWREADY;
      1:       return WREADY;
      default: return ARREADY;
    endcase
  endfunction

  // Wait (bounded) for the ready, then let the handshake edge pass
  task automatic wait_rdy(input int sel, input string tag);
    int t = 0;
    while (!rdy_sig(sel) && t < 50) begin
      @(posedge ACLK); #1; t++;
    end
    if (t >= 50) chk({tag, "_timeout"}, 0, 1);
    @(posedge ACLK); #1;
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bad_beat);
    logic        lg, ok, err;
    logic [31:0] a;
    int          t;
    lg  = burst_legal(len, size, burst);
    err = 1'b0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    wait_rdy(0, "aw");
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge ACLK); #1; end
      WID = 8'($urandom); WDATA = wd[i]; WSTRB = ws[i];
      WLAST = (i == int'(len)) ^ (i == bad_beat);
      WVALID = 1'b1;
      wait_rdy(1, "w");
      WVALID = 1'b0;
      a  = beat_addr(addr, len, size, burst, i);
      ok = lg && ((a >> 2) < DEPTH);
      if (!ok || i == bad_beat) err = 1'b1;
      if (ok) begin
        for (int b = 0; b < 4; b++) if (ws[i][b]) model[a >> 2][b*8 +: 8] = wd[i][b*8 +: 8];
      end
    end
    t = 0;
    while (!BVALID && t < 50) begin @(posedge ACLK); #1; t++; end
    chk("bvalid", BVALID, 1);
    chk("bid", BID, id);
    chk("bresp", BRESP, err ? 2'b10 : 2'b00);
    repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; chk("bvalid_hold", BVALID, 1); end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    chk("bvalid_end", BVALID, 0);
    chk("awready_end", AWREADY, 1);
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic use_pat, input logic [15:0] pat);
    logic        lg, ok;
    logic [31:0] a, exp_d;
    int          beat, t;
    lg = burst_legal(len, size, burst);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    wait_rdy(3, "ar");
    ARVALID = 1'b0;
    beat = 0; t = 0;
    while (beat <= int'(len) && t < 600) begin
      RREADY = use_pat ? pat[t % 16] : 1'($urandom_range(0, 1));
      a  = beat_addr(addr, len, size, burst, beat);
      ok = lg && ((a >> 2) < DEPTH);
      exp_d = 32'd0;
      if (ok) exp_d = model[a >> 2];
      chk("rvalid", RVALID, 1);
      chk("rdata", RDATA, exp_d);
      chk("rresp", RRESP, ok ? 2'b00 : 2'b10);
      chk("rlast", RLAST, beat == int'(len));
      chk("rid", RID, id);
      if (RREADY && RVALID) beat++;
      @(posedge ACLK); #1; t++;
    end
    RREADY = 1'b0;
    chk("r_beats", beat, int'(len) + 1);
    chk("rvalid_end", RVALID, 0);
    chk("arready_end", ARREADY, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bu;
    logic [2:0] sz;
    logic [7:0] ln;
    logic [31:0] ad;
    int kind;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    ARESETn = 1'b0;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
    WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", AWREADY, 0); chk("rst_wready", WREADY, 0); chk("rst_bvalid", BVALID, 0);
    chk("rst_arready", ARREADY, 0); chk("rst_rvalid", RVALID, 0); chk("rst_rlast", RLAST, 0);
    chk("rst_bid", BID, 0); chk("rst_bresp", BRESP, 0); chk("rst_rid", RID, 0);
    chk("rst_rresp", RRESP, 0); chk("rst_rdata", RDATA, 0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("rel_awready", AWREADY, 1); chk("rel_arready", ARREADY, 1);

    // Zero the 64-word working window so the model and the array agree
    for (int i = 0; i < 16; i++) begin wd[i] = 32'd0; ws[i] = 4'hF; end
    for (int k = 0; k < 4; k++) do_write(8'(k), 32'(k * 64), 8'd15, 3'd2, 2'd1, -1);

    // INCR burst at 0x10 then read back
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    do_write(8'h5A, 32'h10, 8'd3, 3'd2, 2'd1, -1);
    do_read(8'h33, 32'h10, 8'd3, 3'd2, 2'd1, 1'b0, 16'h0);
    chk("incr_word4", model[4], 32'hA0);

    // Partial strobe merge
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(8'h01, 32'h40, 8'd0, 3'd2, 2'd1, -1);
    wd[0] = 32'hDEADBEEF; ws[0] = 4'h3;
    do_write(8'h02, 32'h40, 8'd0, 3'd2, 2'd1, -1);
    do_read(8'h03, 32'h40, 8'd0, 3'd2, 2'd1, 1'b0, 16'h0);
    chk("strb_model", model[16], 32'h1122BEEF);

    // Out-of-range start address
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    do_write(8'h04, 32'(DEPTH * 4), 8'd0, 3'd2, 2'd1, -1);
    do_read(8'h05, 32'(DEPTH * 4), 8'd0, 3'd2, 2'd1, 1'b0, 16'h0);

    // WRAP read from 0x0C
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
    do_write(8'h06, 32'h00, 8'd3, 3'd2, 2'd1, -1);
    do_read(8'h07, 32'h0C, 8'd3, 3'd2, 2'd2, 1'b0, 16'h0);

    // RREADY 1-0-0-1 stall pattern
    do_read(8'h08, 32'h10, 8'd3, 3'd2, 2'd1, 1'b1, 16'hFFF9);

    // WLAST early, reserved burst type, oversize reads
    for (int i = 0; i < 2; i++) begin wd[i] = 32'($urandom); ws[i] = 4'hF; end
    do_write(8'h09, 32'(200 * 4), 8'd1, 3'd2, 2'd1, 0);
    do_write(8'h0A, 32'h20, 8'd1, 3'd2, 2'd3, -1);
    do_read(8'h0B, 32'h20, 8'd1, 3'd3, 2'd1, 1'b0, 16'h0);

    // Randomized mix inside the window with occasional illegal and out-of-range bursts
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      bu = (kind < 3) ? 2'd0 : (kind < 7) ? 2'd1 : (kind < 9) ? 2'd2 : 2'd3;
      sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if (bu == 2'd2) begin
        case ($urandom_range(0, 4))
          0: ln = 8'd1; 1: ln = 8'd3; 2: ln = 8'd7; 3: ln = 8'd15; default: ln = 8'd2;
        endcase
      end else begin
        ln = 8'($urandom_range(0, 7));
      end
      ad = ($urandom_range(0, 15) == 0) ? 32'(DEPTH * 4 + $urandom_range(0, 64)) : 32'($urandom_range(0, 128));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(ln); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(8'($urandom), ad, ln, sz, bu, -1);
      end else begin
        do_read(8'($urandom), ad, ln, sz, bu, 1'b0, 16'h0);
      end
    end

    // Reset in the middle of a write burst (outside the window)
    AWID = 8'h77; AWADDR = 32'(100 * 4); AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'd1; AWVALID = 1'b1;
    wait_rdy(0, "aw_rst");
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WDATA = $urandom; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      wait_rdy(1, "w_rst");
    end
    WVALID = 1'b0;
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    chk("abort_awready", AWREADY, 0); chk("abort_wready", WREADY, 0);
    chk("abort_bvalid", BVALID, 0); chk("abort_rvalid", RVALID, 0); chk("abort_arready", ARREADY, 0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("abort_rel_awready", AWREADY, 1); chk("abort_rel_wready", WREADY, 0);
    repeat (3) @(posedge ACLK);
    #1;
    chk("abort_no_b", BVALID, 0);
    do_read(8'h44, 32'h00, 8'd15, 3'd2, 2'd1, 1'b0, 16'h0);
    do_read(8'h45, 32'h40, 8'd15, 3'd2, 2'd1, 1'b0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
